// File: rtl/ld_poll_sched.sv
// ld_poll_sched: alternates measurement requests between two radars, times out silent replies,
// holds the last good distance per channel and derives near-target alarms, faults and the display word.
module ld_poll_sched #(
  parameter int unsigned TIMEOUT_CYC = 2_500_000,
  parameter int unsigned GAP_CYC     = 500_000,
  parameter int unsigned MAX_MISS    = 3,
  parameter logic [19:0] NEAR_TH     = 20'd35
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst_n,
  input  logic        i_en,
  input  logic        i_sel,
  input  logic [1:0]  i_vld,
  input  logic [19:0] i_dist1,
  input  logic [19:0] i_dist2,
  output logic [1:0]  o_trig,
  output logic        o_cur,
  output logic        o_busy,
  output logic [19:0] o_dist1,
  output logic [19:0] o_dist2,
  output logic [1:0]  o_alarm,
  output logic [1:0]  o_fault,
  output logic [23:0] o_show_data
);
  typedef enum logic [1:0] {IDLE, TRIG, WAIT, GAP} state_t;
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYC - 1);
  localparam logic [3:0]  MISS_TH  = 4'(MAX_MISS);
  state_t           state_q, state_d;
  logic             cur_q, cur_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [1:0][3:0]  miss_q, miss_d;
  logic [19:0]      dist1_q, dist1_d, dist2_q, dist2_d;
  logic [1:0]       fault_q, fault_d, alarm_q, alarm_d;
  logic [23:0]      show_q, show_d;
  logic             reply, timeout;
  logic [3:0]       miss_inc;
  always_comb begin
    reply    = (state_q == WAIT) && i_vld[cur_q];
    timeout  = (state_q == WAIT) && (cnt_q == TO_LAST);
    miss_inc = (miss_q[cur_q] == 4'hf) ? 4'hf : miss_q[cur_q] + 4'd1;
    state_d  = state_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q + 32'd1;
    miss_d   = miss_q;
    fault_d  = fault_q;
    dist1_d  = dist1_q;
    dist2_d  = dist2_q;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = i_en ? TRIG : IDLE;
      end
      TRIG: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: if (reply || timeout) begin
        cnt_d   = '0;
        state_d = GAP;
      end
      GAP: if (cnt_q == GAP_LAST) begin
        cnt_d   = '0;
        cur_d   = !cur_q;
        state_d = i_en ? TRIG : IDLE;
      end
    endcase
    // a reply in the timeout cycle still counts as a good reply
    if (reply) begin
      miss_d[cur_q]  = '0;
      fault_d[cur_q] = 1'b0;
      dist1_d        = cur_q ? dist1_q : i_dist1;
      dist2_d        = cur_q ? i_dist2 : dist2_q;
    end else if (timeout) begin
      miss_d[cur_q]  = miss_inc;
      fault_d[cur_q] = fault_q[cur_q] | (miss_inc >= MISS_TH);
    end
    alarm_d[0] = (dist1_d <= NEAR_TH) && (dist1_d != '0) && !fault_d[0];
    alarm_d[1] = (dist2_d <= NEAR_TH) && (dist2_d != '0) && !fault_d[1];
    show_d     = {4'd0, i_sel ? dist2_q : dist1_q};
  end
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q <= IDLE;
      cur_q   <= 1'b0;
      cnt_q   <= '0;
      miss_q  <= '0;
      dist1_q <= '0;
      dist2_q <= '0;
      fault_q <= '0;
      alarm_q <= '0;
      show_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      miss_q  <= miss_d;
      dist1_q <= dist1_d;
      dist2_q <= dist2_d;
      fault_q <= fault_d;
      alarm_q <= alarm_d;
      show_q  <= show_d;
    end
  end
  assign o_trig      = (state_q == TRIG) ? (cur_q ? 2'b10 : 2'b01) : 2'b00;
  assign o_cur       = cur_q;
  assign o_busy      = state_q != IDLE;
  assign o_dist1     = dist1_q;
  assign o_dist2     = dist2_q;
  assign o_alarm     = alarm_q;
  assign o_fault     = fault_q;
  assign o_show_data = show_q;
endmodule

// File: tb/tb_ld_poll_sched.sv
// tb_ld_poll_sched: directed scenarios with a built-in radar responder and hand-computed expectations.
module tb_ld_poll_sched;
  logic        clk = 1'b0;
  logic        rst_n, i_en, i_sel;
  logic [1:0]  i_vld;
  logic [19:0] i_dist1, i_dist2;
  logic [1:0]  o_trig, o_alarm, o_fault;
  logic        o_cur, o_busy;
  logic [19:0] o_dist1, o_dist2;
  logic [23:0] o_show_data;
  int checks = 0;
  int errors = 0;
  int rep_lat [2];
  int cd [2];
  int n;

  always #5 clk = ~clk;

  ld_poll_sched #(.TIMEOUT_CYC(20), .GAP_CYC(5), .MAX_MISS(3), .NEAR_TH(20'd35)) dut (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_en(i_en), .i_sel(i_sel), .i_vld(i_vld),
    .i_dist1(i_dist1), .i_dist2(i_dist2), .o_trig(o_trig), .o_cur(o_cur), .o_busy(o_busy),
    .o_dist1(o_dist1), .o_dist2(o_dist2), .o_alarm(o_alarm), .o_fault(o_fault),
    .o_show_data(o_show_data)
  );

  // one clock; a radar with rep_lat>0 pulses its valid rep_lat cycles after seeing its trigger
  task automatic step();
    @(posedge clk);
    #1;
    i_vld = 2'b00;
    for (int c = 0; c < 2; c++) begin
      if (cd[c] > 0) begin
        cd[c]--;
        if (cd[c] == 0) i_vld[c] = 1'b1;
      end
      if (o_trig[c] && rep_lat[c] > 0) cd[c] = rep_lat[c];
    end
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic wait_trig(input logic [1:0] want, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (o_trig !== want && cnt < 60);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_en = 1'b0; i_sel = 1'b0; i_vld = 2'b00; i_dist1 = '0; i_dist2 = '0;
    rep_lat = '{0, 0}; cd = '{0, 0};
    steps(2);
    checks++; if (o_trig !== 2'b00) begin errors++; $display("FAIL reset_trig got %b want 00", o_trig); end
    checks++; if (o_cur !== 1'b0) begin errors++; $display("FAIL reset_cur got %b want 0", o_cur); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
    checks++; if (o_dist1 !== 20'd0) begin errors++; $display("FAIL reset_dist1 got %0d want 0", o_dist1); end
    checks++; if (o_dist2 !== 20'd0) begin errors++; $display("FAIL reset_dist2 got %0d want 0", o_dist2); end
    checks++; if (o_alarm !== 2'b00) begin errors++; $display("FAIL reset_alarm got %b want 00", o_alarm); end
    checks++; if (o_fault !== 2'b00) begin errors++; $display("FAIL reset_fault got %b want 00", o_fault); end
    checks++; if (o_show_data !== 24'd0) begin errors++; $display("FAIL reset_show got %0d want 0", o_show_data); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alternation();
    i_dist1 = 20'd100; i_dist2 = 20'd30; rep_lat = '{4, 4};
    i_en = 1'b1;
    wait_trig(2'b01, n);
    checks++; if (n != 1) begin errors++; $display("FAIL first_trig_delay got %0d want 1", n); end
    for (int k = 1; k <= 4; k++) begin
      wait_trig((k % 2) ? 2'b10 : 2'b01, n);
      checks++; if (n != 10) begin errors++; $display("FAIL alt_spacing[%0d] got %0d want 10", k, n); end
    end
    checks++; if (o_dist1 !== 20'd100) begin errors++; $display("FAIL alt_dist1 got %0d want 100", o_dist1); end
    checks++; if (o_dist2 !== 20'd30) begin errors++; $display("FAIL alt_dist2 got %0d want 30", o_dist2); end
    checks++; if (o_alarm !== 2'b10) begin errors++; $display("FAIL alt_alarm got %b want 10", o_alarm); end
    checks++; if (o_fault !== 2'b00) begin errors++; $display("FAIL alt_fault got %b want 00", o_fault); end
  endtask

  task automatic test_timeout_fault();
    rep_lat[1] = 0;
    for (int i = 0; i < 3; i++) begin
      wait_trig(2'b10, n);
      checks++; if (n != 10) begin errors++; $display("FAIL to_trig2_spacing[%0d] got %0d want 10", i, n); end
      steps(20);
      checks++; if (o_fault !== 2'b00) begin errors++; $display("FAIL to_fault_early[%0d] got %b want 00", i, o_fault); end
      step();
      checks++; if (o_fault !== ((i == 2) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL to_fault[%0d] got %b want %b", i, o_fault, (i == 2) ? 2'b10 : 2'b00); end
      checks++; if (o_alarm !== ((i == 2) ? 2'b00 : 2'b10)) begin errors++; $display("FAIL to_alarm[%0d] got %b want %b", i, o_alarm, (i == 2) ? 2'b00 : 2'b10); end
      checks++; if (o_dist2 !== 20'd30) begin errors++; $display("FAIL to_dist2_hold[%0d] got %0d want 30", i, o_dist2); end
      steps(5);
      checks++; if (o_trig !== 2'b01) begin errors++; $display("FAIL to_period[%0d] got %b want 01", i, o_trig); end
    end
    i_dist2 = 20'd50; rep_lat[1] = 4;
    wait_trig(2'b10, n);
    checks++; if (n != 10) begin errors++; $display("FAIL recover_spacing got %0d want 10", n); end
    steps(4);
    checks++; if (o_dist2 !== 20'd30) begin errors++; $display("FAIL recover_early got %0d want 30", o_dist2); end
    step();
    checks++; if (o_dist2 !== 20'd50) begin errors++; $display("FAIL recover_dist2 got %0d want 50", o_dist2); end
    checks++; if (o_fault !== 2'b00) begin errors++; $display("FAIL recover_fault got %b want 00", o_fault); end
    checks++; if (o_alarm !== 2'b00) begin errors++; $display("FAIL recover_alarm got %b want 00", o_alarm); end
  endtask

  task automatic test_collision();
    rep_lat[1] = 0;
    wait_trig(2'b10, n);
    checks++; if (n != 15) begin errors++; $display("FAIL col_first got %0d want 15", n); end
    for (int i = 0; i < 2; i++) begin
      wait_trig(2'b01, n);
      checks++; if (n != 26) begin errors++; $display("FAIL col_miss_period[%0d] got %0d want 26", i, n); end
      wait_trig(2'b10, n);
      checks++; if (n != 10) begin errors++; $display("FAIL col_ch0_period[%0d] got %0d want 10", i, n); end
    end
    steps(20);
    i_vld = 2'b10; i_dist2 = 20'd33;
    step();
    checks++; if (o_dist2 !== 20'd33) begin errors++; $display("FAIL col_dist2 got %0d want 33", o_dist2); end
    checks++; if (o_fault !== 2'b00) begin errors++; $display("FAIL col_fault got %b want 00", o_fault); end
    checks++; if (o_alarm !== 2'b10) begin errors++; $display("FAIL col_alarm got %b want 10", o_alarm); end
    wait_trig(2'b01, n);
    checks++; if (n != 5) begin errors++; $display("FAIL col_gap got %0d want 5", n); end
    i_dist1 = 20'd64;
    steps(2);
    i_vld = 2'b10; i_dist2 = 20'd7;
    steps(3);
    checks++; if (o_dist1 !== 20'd64) begin errors++; $display("FAIL foreign_own_dist1 got %0d want 64", o_dist1); end
    checks++; if (o_dist2 !== 20'd33) begin errors++; $display("FAIL foreign_dist2 got %0d want 33", o_dist2); end
    step();
    i_dist1 = 20'd9; i_vld = 2'b01;
    step();
    i_dist1 = 20'd100; i_dist2 = 20'd33;
    step();
    checks++; if (o_dist1 !== 20'd64) begin errors++; $display("FAIL gap_reply_dist1 got %0d want 64", o_dist1); end
  endtask

  task automatic test_stop();
    int extra;
    rep_lat = '{4, 4}; i_dist2 = 20'd30;
    wait_trig(2'b10, n);
    checks++; if (n != 2) begin errors++; $display("FAIL stop_trig got %0d want 2", n); end
    steps(2);
    i_en = 1'b0;
    steps(3);
    checks++; if (o_dist2 !== 20'd30) begin errors++; $display("FAIL stop_dist2 got %0d want 30", o_dist2); end
    checks++; if (o_alarm !== 2'b10) begin errors++; $display("FAIL stop_alarm got %b want 10", o_alarm); end
    steps(4);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL stop_busy_gap got %b want 1", o_busy); end
    step();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL stop_idle got %b want 0", o_busy); end
    checks++; if (o_cur !== 1'b0) begin errors++; $display("FAIL stop_cur got %b want 0", o_cur); end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_trig !== 2'b00) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL stop_no_trig got %0d want 0", extra); end
  endtask

  task automatic test_display();
    checks++; if (o_show_data !== 24'd64) begin errors++; $display("FAIL show_ch1 got %0d want 64", o_show_data); end
    i_sel = 1'b1;
    #1;
    checks++; if (o_show_data !== 24'd64) begin errors++; $display("FAIL show_hold got %0d want 64", o_show_data); end
    step();
    checks++; if (o_show_data !== 24'd30) begin errors++; $display("FAIL show_ch2 got %0d want 30", o_show_data); end
    i_sel = 1'b0;
    step();
    checks++; if (o_show_data !== 24'd64) begin errors++; $display("FAIL show_back got %0d want 64", o_show_data); end
  endtask

  task automatic test_reset_mid();
    i_en = 1'b1;
    wait_trig(2'b01, n);
    checks++; if (n != 1) begin errors++; $display("FAIL rm_trig got %0d want 1", n); end
    steps(2);
    rst_n = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b want 0", o_busy); end
    checks++; if (o_trig !== 2'b00) begin errors++; $display("FAIL rm_trig_out got %b want 00", o_trig); end
    checks++; if (o_dist1 !== 20'd0) begin errors++; $display("FAIL rm_dist1 got %0d want 0", o_dist1); end
    checks++; if (o_dist2 !== 20'd0) begin errors++; $display("FAIL rm_dist2 got %0d want 0", o_dist2); end
    checks++; if (o_alarm !== 2'b00) begin errors++; $display("FAIL rm_alarm got %b want 00", o_alarm); end
    checks++; if (o_fault !== 2'b00) begin errors++; $display("FAIL rm_fault got %b want 00", o_fault); end
    checks++; if (o_show_data !== 24'd0) begin errors++; $display("FAIL rm_show got %0d want 0", o_show_data); end
    cd = '{0, 0};
    rst_n = 1'b1;
    wait_trig(2'b01, n);
    checks++; if (n != 1) begin errors++; $display("FAIL rm_restart got %0d want 1", n); end
    checks++; if (o_cur !== 1'b0) begin errors++; $display("FAIL rm_cur got %b want 0", o_cur); end
  endtask

  initial begin
    test_reset();
    test_alternation();
    test_timeout_fault();
    test_collision();
    test_stop();
    test_display();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
